// File: rtl/mips_pkg.sv
// mips_pkg: shared encodings for the EX-stage multiply/divide unit.
//   md_op_e    : op field encodings for MULT/MULTU/DIV/DIVU
//   md_state_e : iteration FSM states
//   ITER_DEF   : default number of single-bit iterations per operation
//   abs32      : two's-complement magnitude (0x8000_0000 maps to itself,
//                which as an unsigned value is the correct magnitude)
package mips_pkg;

  localparam int ITER_DEF = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_FIX  = 2'b11
  } md_state_e;

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO.
// One multiplier bit (shift-add) or one quotient bit (restoring) per cycle on
// unsigned magnitudes; signs are applied in a final FIX cycle.
//
// Ports:
//   clk, rst        rising-edge clock, async active-high reset
//   start, op       launch request and op encoding (sampled only in IDLE)
//   a, b            rs / rt operands (sampled only on the start edge)
//   mthi, mtlo      direct HI/LO writes of wdata (IDLE, start low only)
//   busy            operation in flight (stall request to hazard unit)
//   hi, lo          architectural HI/LO registers
//
// state   | meaning
// --------+----------------------------------------------------
// ST_IDLE | waiting for start; mthi/mtlo honoured here
// ST_MUL  | shift-add iterations on r_acc
// ST_DIV  | restoring-division iterations on r_rem / r_acc[31:0]
// ST_FIX  | sign correction / divide-by-zero, write HI/LO
module muldiv_unit
  import mips_pkg::*;
#(
  parameter int ITER = ITER_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  md_state_e   r_state;
  md_state_e   w_state_nxt;
  logic [5:0]  r_cnt;
  md_op_e      r_op;
  logic        r_a_neg;
  logic        r_b_neg;
  logic        r_b_zero;
  logic [31:0] r_a_raw;
  // multiplicand (MUL) or divisor (DIV)
  logic [31:0] r_mcand;
  // MUL: {partial product, remaining multiplier bits}
  // DIV: [31:0] dividend bits shifting out / quotient bits shifting in
  logic [63:0] r_acc;
  logic [32:0] r_rem;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_last;
  logic        w_signed;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [32:0] w_mul_sum;
  logic [33:0] w_div_shift;
  logic [33:0] w_div_diff;
  logic        w_div_ge;
  logic [63:0] w_prod_fix;
  logic [31:0] w_quot_fix;
  logic [31:0] w_rem_fix;

  assign w_last   = (r_cnt == 6'(ITER - 1));
  assign w_signed = ~r_op[0];

  assign w_a_mag = op[0] ? a : abs32(a);
  assign w_b_mag = op[0] ? b : abs32(b);

  assign w_mul_sum = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_mcand} : 33'd0);

  // The shifted remainder is below 2^33, so a borrow always shows up in bit 33.
  assign w_div_shift = {r_rem, r_acc[31]};
  assign w_div_diff  = w_div_shift - {2'b00, r_mcand};
  assign w_div_ge    = ~w_div_diff[33];

  assign w_prod_fix = (w_signed && (r_a_neg ^ r_b_neg)) ? (~r_acc + 64'd1) : r_acc;
  assign w_quot_fix = (w_signed && (r_a_neg ^ r_b_neg)) ? (~r_acc[31:0] + 32'd1) : r_acc[31:0];
  assign w_rem_fix  = (w_signed && r_a_neg) ? (~r_rem[31:0] + 32'd1) : r_rem[31:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = op[1] ? ST_DIV : ST_MUL;
      ST_MUL:  if (w_last) w_state_nxt = ST_FIX;
      ST_DIV:  if (w_last) w_state_nxt = ST_FIX;
      ST_FIX:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_op     <= MD_MULT;
      r_a_neg  <= 1'b0;
      r_b_neg  <= 1'b0;
      r_b_zero <= 1'b0;
      r_a_raw  <= '0;
      r_mcand  <= '0;
      r_acc    <= '0;
      r_rem    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_op     <= md_op_e'(op);
            r_a_neg  <= a[31];
            r_b_neg  <= b[31];
            r_b_zero <= (b == 32'd0);
            r_a_raw  <= a;
            r_mcand  <= op[1] ? w_b_mag : w_a_mag;
            r_acc    <= {32'd0, (op[1] ? w_a_mag : w_b_mag)};
            r_rem    <= '0;
            r_cnt    <= '0;
          end else begin
            if (mthi) r_hi <= wdata;
            if (mtlo) r_lo <= wdata;
          end
        end
        ST_MUL: begin
          r_acc <= {w_mul_sum, r_acc[31:1]};
          r_cnt <= r_cnt + 6'd1;
        end
        ST_DIV: begin
          r_rem        <= w_div_ge ? w_div_diff[32:0] : w_div_shift[32:0];
          r_acc[31:0]  <= {r_acc[30:0], w_div_ge};
          r_cnt        <= r_cnt + 6'd1;
        end
        ST_FIX: begin
          if (r_op[1]) begin
            // Divide by zero reports the raw dividend regardless of sign.
            if (r_b_zero) begin
              r_hi <= r_a_raw;
              r_lo <= 32'hFFFF_FFFF;
            end else begin
              r_hi <= w_rem_fix;
              r_lo <= w_quot_fix;
            end
          end else begin
            r_hi <= w_prod_fix[63:32];
            r_lo <= w_prod_fix[31:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != ST_IDLE);
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    string       name;
  } exp_t;

  exp_t sb_q[$];

  muldiv_unit #(.ITER(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .wdata (wdata),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: on every busy falling edge, pop the expected result and compare.
  logic prev_busy = 1'b0;
  int   busy_cnt  = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_busy = 1'b0;
      busy_cnt  = 0;
    end else begin
      if (busy) busy_cnt++;
      if (prev_busy && !busy) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_result: got hi=%h lo=%h with no expectation queued", hi, lo);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check32({e.name, "_hi"}, hi, e.hi);
          check32({e.name, "_lo"}, lo, e.lo);
          check32({e.name, "_busy_cycles"}, 32'(busy_cnt), 32'd33);
        end
        busy_cnt = 0;
      end
      prev_busy = busy;
    end
  end

  task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] eh, input logic [31:0] el, input string name,
                        input bit expect_result);
    exp_t e;
    @(negedge clk);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    if (expect_result) begin
      e.hi = eh;
      e.lo = el;
      e.name = name;
      sb_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    // Scramble operands: they must only be sampled on the start edge.
    op = 2'($urandom);
    a  = $urandom;
    b  = $urandom;
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (busy && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (busy) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: busy still %b after %0d cycles, required 0", name, busy, k);
    end
    @(negedge clk);
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] eh, input logic [31:0] el, input string name);
    launch(o, x, y, eh, el, name, 1'b1);
    wait_idle(name);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    mthi = 1'b0; mtlo = 1'b0; wdata = '0;
    repeat (2) @(negedge clk);
    check32("reset_busy", 32'(busy), 32'd0);
    check32("reset_hi", hi, 32'd0);
    check32("reset_lo", lo, 32'd0);
    rst = 1'b0;

    run_op(MD_MULT,  32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult_neg3x5");
    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
    run_op(MD_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg7by2");

    // DIVU with an mtlo attempt in the middle of the operation.
    launch(MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, "divu_100by7", 1'b1);
    repeat (5) @(negedge clk);
    mtlo = 1'b1; wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    mtlo = 1'b0;
    check32("hold_lo_midop", lo, 32'hFFFF_FFFD);
    check32("hold_hi_midop", hi, 32'hFFFF_FFFF);
    wait_idle("divu_100by7");

    // mthi once idle: visible one cycle later.
    mthi = 1'b1; wdata = 32'hCAFE_0001;
    @(negedge clk);
    mthi = 1'b0;
    check32("mthi_hi", hi, 32'hCAFE_0001);
    check32("mthi_lo_kept", lo, 32'd14);

    run_op(MD_DIVU, 32'h1234_5678, 32'd0,        32'h1234_5678, 32'hFFFF_FFFF, "divu_by0");
    run_op(MD_DIV,  32'h1234_5678, 32'd0,        32'h1234_5678, 32'hFFFF_FFFF, "div_by0");
    run_op(MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, "div_minovf");
    run_op(MD_DIV,  32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, "div_7byneg2");
    run_op(MD_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,        32'd1,         "mult_neg1sq");

    // start has priority over simultaneous mthi/mtlo.
    @(negedge clk);
    op = MD_MULTU; a = 32'h0001_0000; b = 32'h0001_0000; start = 1'b1;
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h1111_1111;
    begin
      exp_t e;
      e.hi = 32'd1; e.lo = 32'd0; e.name = "multu_2p32";
      sb_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    a = $urandom; b = $urandom;
    check32("start_prio_hi", hi, 32'd0);
    check32("start_prio_lo", lo, 32'd1);
    wait_idle("multu_2p32");

    // mthi and mtlo together write both registers.
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'hA5A5_A5A5;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    check32("mthilo_hi", hi, 32'hA5A5_A5A5);
    check32("mthilo_lo", lo, 32'hA5A5_A5A5);

    // Reset in the middle of a MULT discards it.
    launch(MD_MULT, 32'd3, 32'd3, 32'd0, 32'd0, "aborted", 1'b0);
    repeat (9) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check32("midrst_busy", 32'(busy), 32'd0);
    check32("midrst_hi", hi, 32'd0);
    check32("midrst_lo", lo, 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;

    run_op(MD_MULT, 32'd7, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFD6, "mult_after_rst");

    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d results outstanding, required 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
